// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl_if
//  Description : Hazard-request / pipeline-enable bundle between the ID-stage
//                hazard units and the central stall/flush scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    // Requests from the hazard units and statistics control
    logic             brc_stall_req;
    logic             lu_stall_req;
    logic             branch_taken;
    logic             mdu_start;
    logic             cnt_clr;

    // Pipeline register controls back to the datapath
    logic             PCWrite;
    logic             IFID_write;
    logic             IFID_flush;
    logic             IDEX_write;
    logic             IDEX_flush;
    logic             EXMEM_flush;

    // Status and statistics
    logic             mdu_busy;
    logic             mdu_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Hazard-unit side: raises requests, consumes enables
    modport master (
        output brc_stall_req, lu_stall_req, branch_taken, mdu_start, cnt_clr,
        input  PCWrite, IFID_write, IFID_flush, IDEX_write, IDEX_flush,
        input  EXMEM_flush, mdu_busy, mdu_err, stall_cnt, flush_cnt
    );

    // Scheduler side: consumes requests, drives enables
    modport slave (
        input  brc_stall_req, lu_stall_req, branch_taken, mdu_start, cnt_clr,
        output PCWrite, IFID_write, IFID_flush, IDEX_write, IDEX_flush,
        output EXMEM_flush, mdu_busy, mdu_err, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : Central stall/flush scheduler for the 5-stage MIPS pipeline.
//                Prioritises MDU occupancy of EX over data stalls over taken
//                branches, and keeps saturating stall/flush statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int MDU_LAT = 4,   // cycles a mult/div holds EX, incl. issue (2..255)
    parameter int CNT_W   = 16   // statistics counter width
) (
    input  wire                    clk,
    input  wire                    rst,
    pipe_stall_ctrl_if.slave       bus
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } state_t;

    // hold is loaded with MDU_LAT-1 so that MDU_WAIT spans MDU_LAT-1 cycles
    localparam logic [7:0]       c_hold_init = 8'(MDU_LAT - 1);
    localparam logic [7:0]       c_hold_one  = 8'd1;
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_hold;
    logic [7:0]       w_hold_nxt;
    logic             r_mdu_err;
    logic             w_err_set;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_mdu_hold;
    logic             w_data_stall;
    logic             w_pcwrite;
    logic             w_ifid_write;
    logic             w_ifid_flush;
    logic             w_idex_write;
    logic             w_idex_flush;
    logic             w_exmem_flush;

    // State and hold-counter registers; reset drops MDU_WAIT immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_hold  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Next-state, hold countdown and prioritised per-stage enables
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_err_set     = 1'b0;
        w_pcwrite     = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_write  = 1'b1;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;

        w_mdu_hold   = (r_state == ST_MDU_WAIT) || bus.mdu_start;
        w_data_stall = bus.brc_stall_req || bus.lu_stall_req;

        case (r_state)
            ST_RUN: begin
                if (bus.mdu_start) begin
                    w_state_nxt = ST_MDU_WAIT;
                    w_hold_nxt  = c_hold_init;
                end
            end
            ST_MDU_WAIT: begin
                // A second start cannot be accepted; flag it, keep the timing
                w_err_set = bus.mdu_start;
                if (r_hold == c_hold_one) begin
                    w_state_nxt = ST_RUN;
                    w_hold_nxt  = 8'd0;
                end else begin
                    w_hold_nxt  = r_hold - c_hold_one;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_hold_nxt  = 8'd0;
            end
        endcase

        if (rst) begin
            // Freeze everything and fill the pipe with bubbles while in reset
            w_pcwrite     = 1'b0;
            w_ifid_write  = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_write  = 1'b0;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
        end else if (w_mdu_hold) begin
            // EX occupied: freeze PC/IF/ID/EX, bubble into MEM; ID requests wait
            w_pcwrite     = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_exmem_flush = 1'b1;
        end else if (w_data_stall) begin
            // Operands stale: hold IF/ID, bubble into EX; branch result is untrusted
            w_pcwrite     = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_flush  = 1'b1;
        end else if (bus.branch_taken) begin
            // Redirect: PC takes target, kill the wrong-path fetch
            w_ifid_flush  = 1'b1;
        end
    end

    // Sticky error for a start request while the MDU is still busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mdu_err <= 1'b0;
        end else if (w_err_set) begin
            r_mdu_err <= 1'b1;
        end
    end

    // Saturating stall counter; clear has priority over counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (!w_pcwrite && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    // Saturating flush counter; clear has priority over counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_flush_cnt <= '0;
        end else if (w_ifid_flush && (r_flush_cnt != c_cnt_max)) begin
            r_flush_cnt <= r_flush_cnt + c_cnt_one;
        end
    end

    assign bus.PCWrite     = w_pcwrite;
    assign bus.IFID_write  = w_ifid_write;
    assign bus.IFID_flush  = w_ifid_flush;
    assign bus.IDEX_write  = w_idex_write;
    assign bus.IDEX_flush  = w_idex_flush;
    assign bus.EXMEM_flush = w_exmem_flush;
    assign bus.mdu_busy    = (r_state == ST_MDU_WAIT);
    assign bus.mdu_err     = r_mdu_err;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stall_ctrl
//  Description : Directed scoreboard bench for pipe_stall_ctrl
//                (MDU_LAT=4, CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    // Control vector order: {PCWrite, IFID_write, IFID_flush,
    //                        IDEX_write, IDEX_flush, EXMEM_flush}
    localparam logic [5:0] c_def = 6'b110100;
    localparam logic [5:0] c_rst = 6'b001011;
    localparam logic [5:0] c_mdu = 6'b000001;
    localparam logic [5:0] c_dat = 6'b000110;
    localparam logic [5:0] c_brt = 6'b111100;

    typedef struct packed {
        logic [5:0] ctl;
        logic       busy;
        logic       err;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    logic  clk;
    logic  rst;
    exp_t  r_q[$];
    int    checks;
    int    errors;
    int    cyc;

    pipe_stall_ctrl_if #(.CNT_W(4)) bus ();

    pipe_stall_ctrl #(
        .MDU_LAT (4),
        .CNT_W   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus shortly after the edge and queue its expectation
    task automatic step(input logic r, input logic b, input logic l,
                        input logic t, input logic m, input logic c,
                        input logic [5:0] ctl, input logic busy,
                        input logic err, input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #2;
        rst               = r;
        bus.brc_stall_req = b;
        bus.lu_stall_req  = l;
        bus.branch_taken  = t;
        bus.mdu_start     = m;
        bus.cnt_clr       = c;
        e.ctl  = ctl;
        e.busy = busy;
        e.err  = err;
        e.sc   = sc[3:0];
        e.fc   = fc[3:0];
        r_q.push_back(e);
    endtask

    // Monitor: mid-cycle, pop the expectation for this cycle and compare
    initial begin
        exp_t  e;
        logic [5:0] act;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (r_q.size() > 0) begin
                e   = r_q.pop_front();
                act = {bus.PCWrite, bus.IFID_write, bus.IFID_flush,
                       bus.IDEX_write, bus.IDEX_flush, bus.EXMEM_flush};
                checks++;
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl cyc %0d: got %b want %b", cyc, act, e.ctl);
                end
                checks++;
                if (bus.mdu_busy !== e.busy) begin
                    errors++;
                    $display("FAIL mdu_busy cyc %0d: got %b want %b", cyc, bus.mdu_busy, e.busy);
                end
                checks++;
                if (bus.mdu_err !== e.err) begin
                    errors++;
                    $display("FAIL mdu_err cyc %0d: got %b want %b", cyc, bus.mdu_err, e.err);
                end
                checks++;
                if (bus.stall_cnt !== e.sc) begin
                    errors++;
                    $display("FAIL stall_cnt cyc %0d: got %0d want %0d", cyc, bus.stall_cnt, e.sc);
                end
                checks++;
                if (bus.flush_cnt !== e.fc) begin
                    errors++;
                    $display("FAIL flush_cnt cyc %0d: got %0d want %0d", cyc, bus.flush_cnt, e.fc);
                end
                cyc++;
            end
        end
    end

    // Bound the whole run
    initial begin
        #100000;
        $display("FAIL timeout: got no end of run want end within 100000 time units");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.brc_stall_req = 1'b0;
        bus.lu_stall_req  = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.mdu_start     = 1'b0;
        bus.cnt_clr       = 1'b0;

        //   rst  brc  lu   tkn  mdu  clr   ctl    busy err  sc  fc
        // Reset, then release into RUN with default enables
        step(1, 0, 0, 0, 0, 0, c_rst, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, c_rst, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, c_def, 0, 0, 0, 0);
        // Load-use for two cycles
        step(0, 0, 1, 0, 0, 0, c_dat, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, c_dat, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, c_def, 0, 0, 2, 0);
        // Branch stall beats taken branch; then the taken branch alone
        step(0, 1, 0, 1, 0, 0, c_dat, 0, 0, 2, 0);
        step(0, 0, 0, 1, 0, 0, c_brt, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0, 0, c_def, 0, 0, 3, 1);
        // Reset mid-run clears counters at once
        step(1, 0, 0, 0, 0, 0, c_rst, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, c_def, 0, 0, 0, 0);
        // MDU start with load-use held: 4 hold cycles, then the data stall
        step(0, 0, 1, 0, 1, 0, c_mdu, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, c_mdu, 1, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0, c_mdu, 1, 0, 2, 0);
        step(0, 0, 1, 0, 0, 0, c_mdu, 1, 0, 3, 0);
        step(0, 0, 1, 0, 0, 0, c_dat, 0, 0, 4, 0);
        step(0, 0, 0, 0, 0, 0, c_def, 0, 0, 5, 0);
        // Clear wins over the increment of an MDU issue cycle; second start errs
        step(0, 0, 0, 0, 1, 1, c_mdu, 0, 0, 5, 0);
        step(0, 0, 0, 0, 1, 0, c_mdu, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, c_mdu, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, c_mdu, 1, 1, 2, 0);
        step(0, 0, 0, 0, 0, 0, c_def, 0, 1, 3, 0);
        // Twenty stall cycles saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 0, 0, 0, c_dat, 0, 1, (3 + i > 15) ? 15 : 3 + i, 0);
        end
        step(0, 0, 0, 0, 0, 0, c_def, 0, 1, 15, 0);
        // Clear together with a stall cycle leaves zero
        step(0, 0, 1, 0, 0, 1, c_dat, 0, 1, 15, 0);
        step(0, 0, 0, 0, 1, 0, c_mdu, 0, 1, 0, 0);
        // Reset during MDU_WAIT drops busy and the sticky error
        step(1, 0, 0, 0, 0, 0, c_rst, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, c_def, 0, 0, 0, 0);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (r_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", r_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
